// File: rtl/count_seq_pkg.sv
// Shared types and defaults for the count sequencer: state encoding and
// default widths.
package count_seq_pkg;

  localparam int CW_DEFAULT  = 8;
  localparam int DIV_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  function automatic logic is_busy(input state_t s);
    return (s == ST_RUN) || (s == ST_PAUSE);
  endfunction

endpackage

// File: rtl/count_sequencer_tick_gen.sv
// Prescaler for the count sequencer: emits a one-cycle tick every DIV cycles
// of run, holds while run is low, and restarts from zero on sclr.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic sclr,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(DIV - 1);

  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (sclr) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= (cnt_q == LAST) ? 8'd0 : cnt_q + 8'd1;
    end
  end

  assign tick = run & (cnt_q == LAST);

endmodule

// File: rtl/count_sequencer.sv
// Control FSM for an external counter datapath (one-shot or wrapping count to
// limit). Define COUNT_SEQ_PRESCALE_EN to slow counting to one step per DIV cycles.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT,
  parameter int CW  = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          pause,
  input  logic          clr,
  input  logic          mode,
  input  logic [CW-1:0] limit,
  input  logic [CW-1:0] count_q,
  output logic          cnt_en,
  output logic          cnt_clr,
  output logic          done,
  output logic          busy,
  output logic [1:0]    state
);

  state_t state_q, state_d;
  logic   cnt_clr_q, cnt_clr_d;
  logic   done_q, done_d;
  logic   tick;
  logic   at_limit;
  logic   hit;

`ifdef COUNT_SEQ_PRESCALE_EN
  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .run   (state_q == ST_RUN),
    .sclr  (cnt_clr_q),
    .tick  (tick)
  );
`else
  localparam logic [7:0] DIV_B = 8'(DIV);
  logic unused_div;
  assign unused_div = ^DIV_B;
  assign tick = 1'b1;
`endif

  assign at_limit = (count_q == limit);
  // A count that was just cleared is not yet valid, so ignore it for the hit.
  assign hit = at_limit & ~cnt_clr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_clr_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_clr_q <= cnt_clr_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_clr_d = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr) begin
          cnt_clr_d = 1'b1;
        end else if (start) begin
          state_d   = ST_RUN;
          cnt_clr_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (clr) begin
          state_d   = ST_IDLE;
          cnt_clr_d = 1'b1;
        end else if (pause) begin
          state_d = ST_PAUSE;
        end else if (hit) begin
          done_d = 1'b1;
          if (mode) begin
            cnt_clr_d = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_PAUSE: begin
        if (clr) begin
          state_d   = ST_IDLE;
          cnt_clr_d = 1'b1;
        end else if (start) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (clr) begin
          state_d   = ST_IDLE;
          cnt_clr_d = 1'b1;
        end else if (start) begin
          state_d   = ST_RUN;
          cnt_clr_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset gates the combinational outputs so the datapath never steps during reset.
  assign cnt_en  = ~reset & (state_q == ST_RUN) & tick & ~cnt_clr_q & ~at_limit;
  assign busy    = ~reset & is_busy(state_q);
  assign cnt_clr = cnt_clr_q;
  assign done    = done_q;
  assign state   = state_q;

endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 Parameter DIV, default 4, SHALL set the clock cycles per count tick (2..255); it is used only when PRESCALE_EN is defined.
REQ-003 Parameter CW, default 8, SHALL set the counter datapath width.
REQ-004 Port clk, input, 1: system clock.
REQ-005 Port reset, input, 1: synchronous active-high reset.
REQ-006 Port start, input, 1: start from IDLE/DONE (with clear), or resume from PAUSE.
REQ-007 Port pause, input, 1: freeze counting while in RUN.
REQ-008 Port clr, input, 1: abort, clear the counter and return to IDLE.
REQ-009 Port mode, input, 1: 0 = one-shot, 1 = wrap (auto-restart).
REQ-010 Port limit, input, CW: terminal count value.
REQ-011 Port count_q, input, CW: current value fed back from the counter datapath.
REQ-012 Port cnt_en, output, 1: count enable to the datapath; the datapath increments at an edge where cnt_en=1.
REQ-013 Port cnt_clr, output, 1: synchronous active-high clear to the datapath.
REQ-014 Port done, output, 1: one-cycle terminal-count pulse.
REQ-015 Port busy, output, 1: high in RUN or PAUSE.
REQ-016 Port state, output, 2: state code, with IDLE=00, RUN=01, PAUSE=10, DONE=11.

Function
REQ-017 The FSM states SHALL be IDLE, RUN, PAUSE and DONE; input priority SHALL be clr > pause > start.
REQ-018 IDLE: start SHALL move to RUN and register cnt_clr=1 for exactly one cycle; otherwise the FSM SHALL stay in IDLE.
REQ-019 RUN, exits and holds:
- clr SHALL move to IDLE with a one-cycle cnt_clr pulse.
- pause SHALL move to PAUSE with no clear.
- Otherwise the FSM SHALL stay in RUN.
REQ-020 RUN, terminal count (hit) SHALL be count_q==limit while cnt_clr=0; on a hit with no clr or pause:
- mode=0: next state DONE, done=1.
- mode=1: stay in RUN, done=1, cnt_clr pulsed for one cycle.
REQ-021 PAUSE: clr SHALL move to IDLE with a cnt_clr pulse; start SHALL move to RUN with no clear; otherwise the FSM SHALL stay in PAUSE.
REQ-022 DONE: start SHALL move to RUN with a cnt_clr pulse; clr SHALL move to IDLE with a cnt_clr pulse; otherwise the FSM SHALL stay in DONE.
REQ-023 cnt_en SHALL be combinational: (state==RUN) & tick & ~cnt_clr & ~(count_q==limit).
REQ-024 done and cnt_clr SHALL be registered single-cycle pulses; busy and state SHALL be decoded from the state register.
REQ-025 Latency, with no prescale and mode=0:
- start sampled at edge E0 gives cnt_clr=1 after E0 and count_q=0 after E1.
- The first increment occurs at E2; count_q reaches limit after E(limit+1).
- done=1 for one cycle after E(limit+2).
REQ-026 limit=0 SHALL produce no increments and a done pulse two edges after the clear edge.
REQ-027 A change to limit while in RUN SHALL take effect immediately.
REQ-028 If count_q>limit, counting SHALL continue and wrap modulo 2^CW until it equals limit.
REQ-029 pause and start high together in RUN SHALL give PAUSE; clr with any other input SHALL give IDLE.

Reset
REQ-030 While reset=1 at an edge, the block SHALL go to state IDLE with cnt_clr=0, done=0 and the prescaler at 0.
REQ-031 While reset=1, cnt_en SHALL be 0 and busy SHALL be 0.
REQ-032 reset SHALL override all inputs, including mid-RUN; the datapath is not cleared by this block on reset.

Configuration
REQ-033 With COUNT_SEQ_PRESCALE_EN defined:
- tick SHALL be 1 for one cycle every DIV cycles spent in RUN.
- The prescaler SHALL hold in PAUSE and reset to 0 on every cnt_clr pulse.
REQ-034 Without COUNT_SEQ_PRESCALE_EN, tick SHALL be constant 1 and no prescaler logic SHALL exist.

Structure
REQ-035 A shared package count_seq_pkg SHALL hold:
- the state enum and its encodings;
- CW_DEFAULT = 8 and DIV_DEFAULT = 4.
REQ-036 The prescaler SHALL be a sub-module tick_gen (ports clk, reset, run, sclr, tick), instantiated only under COUNT_SEQ_PRESCALE_EN.

Verification
REQ-037 Scenario: mode=0, limit=3, start pulse at E0 -> cnt_clr high after E0; count_q 0,1,2,3; done high exactly once after E5; state=DONE; cnt_en=0 thereafter.
REQ-038 Scenario: mode=1, limit=2 -> done pulses every 4 cycles (count 0,1,2, then clear); busy stays 1; state stays RUN.
REQ-039 Scenario: pause at count_q=5, held 10 cycles, then start -> count_q holds 5 and cnt_en=0 during pause; counting resumes at 6 with no cnt_clr.
REQ-040 Scenario: clr and pause together in RUN at count_q=7 -> state IDLE, one cnt_clr pulse, count_q=0, no done.
REQ-041 Scenario: reset asserted mid-RUN at count_q=9 -> state IDLE, cnt_en=0, done=0 next cycle; start then restarts from 0; limit=0 gives done with no increment.
REQ-042 Scenario: with COUNT_SEQ_PRESCALE_EN and DIV=4, limit=2 -> increments spaced 4 cycles apart; done pulse follows count_q=2.
